pc_seq_popcount: RTL and testbench
==================================

# pc_seq_popcount

Sequential population-count engine that shares a single `pc_fa_15_4` 15-input parallel counter across a wide input word. The block accepts a `DATA_W`-bit vector through a valid/ready handshake and feeds it through the counter one 15-bit slice per cycle, accumulating the partial counts. It then presents the total through a valid/ready result port. It sits between a wide-vector producer and any consumer that needs a popcount, where a full-width combinational counter tree is too large.

## Interface
- `DATA_W`, default 60: input vector width, range 1..1024; `NS = ceil(DATA_W/15)` slices, the top slice is zero-padded.
- `CNT_W`, default `$clog2(DATA_W+1)`: result width.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset is synchronous and active-high.
- `in_valid` in 1: input word valid.
- `in_ready` out 1: block can accept a word.
- `in_data` in DATA_W: vector to count.
- `out_valid` out 1: result valid.
- `out_ready` in 1: consumer accepts the result.
- `out_count` out CNT_W: number of ones in the accepted word.
- `busy` out 1: high in RUN or DONE.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - `in_ready=1`.
  - On `in_valid && in_ready`: latch `in_data` into shift register `sr`, clear accumulator `acc` and slice index `idx`, then go to RUN.
- RUN, once per cycle:
  - `acc <= acc + pc(sr[14:0])`, where `pc` is the 4-bit count from the `pc_fa_15_4` instance.
  - `sr <= sr >> 15`; `idx <= idx+1`.
  - When `idx == NS-1`, go to DONE.
- DONE:
  - `out_valid=1` and `out_count=acc`, both held stable until `out_ready`.
  - On `out_valid && out_ready`, go to IDLE.
- `in_ready=0` in RUN and DONE. There is no overlap between jobs.
- Arithmetic:
  - `acc` is `CNT_W` bits wide and cannot overflow, because its maximum value is `DATA_W`.
  - The 4-bit slice count is zero-extended before the add.
- Reset values: state IDLE, `acc=0`, `idx=0`, `sr=0`, `out_valid=0`, `out_count=0`, `busy=0`. `in_ready=0` while `rst` is high.
- Reset asserted mid-RUN or mid-DONE: the job is discarded with no result emitted, and the block is in IDLE on the first cycle after `rst` deasserts.
- `in_valid` during RUN or DONE is ignored. The producer must hold it until `in_ready`.
- `out_ready` while `out_valid=0` has no effect.

## Timing
- Input accepted at edge T. RUN occupies cycles T+1..T+NS.
- `out_valid` rises at cycle T+NS+1, giving a latency of NS+1 edges from acceptance to valid.
- A result accepted at edge R puts the block in IDLE at R+1 (`in_ready=1`). The earliest next acceptance is edge R+1.
- Throughput is one word per NS+2 cycles when `out_ready` is held high.
- Combinational paths:
  - `in_ready`, `out_valid` and `busy` are decoded from the registered state only.
  - No input-to-output combinational path exists.

## Configuration
- `PC_SEQ_EARLY_EXIT_EN` defined:
  - In RUN, if the post-shift remainder `sr >> 15` is all zero, go to DONE immediately.
  - RUN lasts 1 to NS cycles.
  - `acc` is unchanged in value, because skipped slices contribute zero.
- `PC_SEQ_EARLY_EXIT_EN` undefined: RUN always lasts exactly NS cycles. This gives fixed latency.

## Structure
- Shared package `pc_seq_pkg` holds:
  - `SLICE_W=15` and `SLICE_CNT_W=4`.
  - The state enum `pc_seq_state_t` {IDLE, RUN, DONE}.
  - The function `ceil_div`, used to compute NS.
- Exactly one sub-module: an instance of `pc_fa_15_4` on `sr[14:0]`.
  - FSM, shifter and accumulator stay in `pc_seq_popcount`.

## Test plan
All scenarios use `DATA_W=60` (NS=4) unless stated.

- **All ones:** `in_data=60'hFFF_FFFF_FFFF_FFFF`, accepted at T, `out_ready=1` → `out_count=60` with `out_valid` at T+5.
  - Without the macro, `busy` is high for exactly 5 cycles.
- **Alternating pattern:** `in_data=60'hAAA_AAAA_AAAA_AAAA` → `out_count=30`.
- **Backpressure:** `out_ready=0` for 10 cycles after `out_valid` → `out_count` is held stable and `in_ready=0` throughout.
  - Raising `out_ready` → IDLE on the next cycle.
- **Early exit** (`PC_SEQ_EARLY_EXIT_EN` defined): `in_data=60'h7` → `out_count=3`, `out_valid` at T+2.
  - `in_data=0` → `out_count=0`, `out_valid` at T+2.
  - Without the macro, both cases have `out_valid` at T+5.
- **Reset mid-operation:** `rst` pulsed for 1 cycle at T+2 of a job → no `out_valid`, `in_ready=1` at T+4.
  - The next word `60'h1` then yields `out_count=1`.
- **Non-multiple width** (`DATA_W=17`, NS=2): all ones → `out_count=17`; the padding bits contribute nothing.
  - Back-to-back words are accepted at the NS+2 interval.

Source files
------------

// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg: shared slice constants, FSM state type and ceil_div helper for pc_seq_popcount
package pc_seq_pkg;
  localparam int SLICE_W = 15;
  localparam int SLICE_CNT_W = 4;
  typedef enum logic [1:0] {IDLE, RUN, DONE} pc_seq_state_t;
  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction
endpackage

// File: rtl/pc_seq_popcount_if.sv
// pc_seq_popcount_if: input word handshake (in_valid/in_ready/in_data), result handshake (out_valid/out_ready/out_count) and busy status
interface pc_seq_popcount_if #(
  parameter int DATA_W = 60,
  parameter int CNT_W = $clog2(DATA_W + 1)
);
  logic in_valid;
  logic in_ready;
  logic [DATA_W-1:0] in_data;
  logic out_valid;
  logic out_ready;
  logic [CNT_W-1:0] out_count;
  logic busy;
  modport master (output in_valid, in_data, out_ready, input in_ready, out_valid, out_count, busy);
  modport slave (input in_valid, in_data, out_ready, output in_ready, out_valid, out_count, busy);
endinterface

// File: rtl/pc_fa_15_4.sv
// pc_fa_15_4: 15-input parallel counter from 11 full adders; ports x_i[14:0] bits in, cnt_o[3:0] number of ones
module pc_fa_15_4 (
  input  logic [14:0] x_i,
  output logic [3:0]  cnt_o
);
  function automatic logic [1:0] fa(input logic a, input logic b, input logic c);
    return {(a & b) | (a & c) | (b & c), a ^ b ^ c};
  endfunction
  logic [1:0] l1 [5];
  logic [1:0] t0, t1, u0, u1, u2, w;
  always_comb begin
    for (int i = 0; i < 5; i++) l1[i] = fa(x_i[3*i], x_i[3*i+1], x_i[3*i+2]);
    t0 = fa(l1[0][0], l1[1][0], l1[2][0]);
    t1 = fa(t0[0], l1[3][0], l1[4][0]);
    u0 = fa(l1[0][1], l1[1][1], l1[2][1]);
    u1 = fa(l1[3][1], l1[4][1], t0[1]);
    u2 = fa(u0[0], u1[0], t1[1]);
    w = fa(u0[1], u1[1], u2[1]);
    cnt_o = {w, u2[0], t1[0]};
  end
endmodule

// File: rtl/pc_seq_popcount.sv
// pc_seq_popcount: sequential popcount, one 15-bit slice per cycle; ports clk, rst, bus (pc_seq_popcount_if.slave); PC_SEQ_EARLY_EXIT_EN ends RUN once the remaining slices are zero
module pc_seq_popcount
  import pc_seq_pkg::*;
#(
  parameter int DATA_W = 60,
  parameter int CNT_W = $clog2(DATA_W + 1)
) (
  input logic clk,
  input logic rst,
  pc_seq_popcount_if.slave bus
);
  localparam int NS = ceil_div(DATA_W, SLICE_W);
  localparam int SR_W = NS * SLICE_W;
  localparam int IDX_W = NS > 1 ? $clog2(NS) : 1;
  pc_seq_state_t state_q, state_d;
  logic [SR_W-1:0] sr_q, sr_d;
  logic [CNT_W-1:0] acc_q, acc_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [SLICE_CNT_W-1:0] slice_cnt;
  logic last;
  pc_fa_15_4 u_pc (.x_i(sr_q[SLICE_W-1:0]), .cnt_o(slice_cnt));
`ifdef PC_SEQ_EARLY_EXIT_EN
  assign last = idx_q == IDX_W'(NS - 1) || (sr_q >> SLICE_W) == '0;
`else
  assign last = idx_q == IDX_W'(NS - 1);
`endif
  // in_ready is gated by rst so no word is taken while reset is held
  assign bus.in_ready = state_q == IDLE && !rst;
  assign bus.out_valid = state_q == DONE;
  assign bus.out_count = state_q == DONE ? acc_q : '0;
  assign bus.busy = state_q != IDLE;
  always_comb begin
    state_d = state_q;
    sr_d = sr_q;
    acc_d = acc_q;
    idx_d = idx_q;
    if (state_q == IDLE && bus.in_valid) begin
      state_d = RUN;
      sr_d = SR_W'(bus.in_data);
      acc_d = '0;
      idx_d = '0;
    end else if (state_q == RUN) begin
      acc_d = acc_q + CNT_W'(slice_cnt);
      sr_d = sr_q >> SLICE_W;
      idx_d = idx_q + IDX_W'(1);
      state_d = last ? DONE : RUN;
    end else if (state_q == DONE && bus.out_ready) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sr_q <= '0;
      acc_q <= '0;
      idx_q <= '0;
    end else begin
      state_q <= state_d;
      sr_q <= sr_d;
      acc_q <= acc_d;
      idx_q <= idx_d;
    end
  end
endmodule

// File: tb/tb_pc_seq_popcount.sv
// tb_pc_seq_popcount: directed-vector self-checking bench for pc_seq_popcount (DATA_W=60 and DATA_W=17)
module tb_pc_seq_popcount;
  logic clk = 0;
  logic rst = 1;
  int checks = 0;
  int failures = 0;
`ifdef PC_SEQ_EARLY_EXIT_EN
  localparam int LAT_SHORT = 2;
`else
  localparam int LAT_SHORT = 5;
`endif
  always #5 clk = ~clk;
  pc_seq_popcount_if #(.DATA_W(60)) a ();
  pc_seq_popcount_if #(.DATA_W(17)) b ();
  pc_seq_popcount #(.DATA_W(60)) dut_a (.clk(clk), .rst(rst), .bus(a));
  pc_seq_popcount #(.DATA_W(17)) dut_b (.clk(clk), .rst(rst), .bus(b));
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic job(input string tag, input logic [59:0] d, input int exp_cnt, input int exp_lat);
    int k;
    int bsy;
    a.in_valid = 1;
    a.in_data = d;
    chk({tag, "_in_ready"}, a.in_ready, 1);
    tick;
    a.in_valid = 0;
    a.in_data = '0;
    k = 1;
    bsy = 0;
    while (!a.out_valid && k < 20) begin
      bsy += int'(a.busy);
      tick;
      k++;
    end
    bsy += int'(a.busy);
    chk({tag, "_latency"}, k, exp_lat);
    chk({tag, "_count"}, a.out_count, exp_cnt);
    chk({tag, "_busy_cycles"}, bsy, exp_lat);
  endtask
  initial begin
    int acc_at[$];
    logic seen;
    a.in_valid = 0; a.in_data = '0; a.out_ready = 1;
    b.in_valid = 0; b.in_data = '0; b.out_ready = 1;
    tick;
    tick;
    chk("rst_in_ready", a.in_ready, 0);
    chk("rst_out_valid", a.out_valid, 0);
    chk("rst_out_count", a.out_count, 0);
    chk("rst_busy", a.busy, 0);
    rst = 0;
    tick;
    chk("idle_in_ready", a.in_ready, 1);
    job("ones", '1, 60, 5);
    tick;
    chk("ones_back_idle", a.in_ready, 1);
    chk("ones_busy_low", a.busy, 0);
    job("alt", 60'hAAA_AAAA_AAAA_AAAA, 30, 5);
    tick;
    job("seven", 60'h7, 3, LAT_SHORT);
    tick;
    job("zero", 60'h0, 0, LAT_SHORT);
    tick;
    a.out_ready = 0;
    job("bp", 60'h123_4567_89AB_CDEF, 32, 5);
    for (int i = 0; i < 10; i++) begin
      tick;
      chk("bp_hold_count", a.out_count, 32);
      chk("bp_hold_valid", a.out_valid, 1);
      chk("bp_in_ready", a.in_ready, 0);
    end
    a.out_ready = 1;
    tick;
    chk("bp_release_ready", a.in_ready, 1);
    chk("bp_release_valid", a.out_valid, 0);
    a.in_valid = 1;
    a.in_data = '1;
    tick;
    a.in_valid = 0;
    seen = a.out_valid;
    tick;
    rst = 1;
    chk("midrst_in_ready_low", a.in_ready, 0);
    seen |= a.out_valid;
    tick;
    rst = 0;
    seen |= a.out_valid;
    tick;
    chk("midrst_in_ready_t4", a.in_ready, 1);
    for (int i = 0; i < 6; i++) begin
      seen |= a.out_valid;
      tick;
    end
    chk("midrst_no_valid", seen, 0);
    job("after_rst", 60'h1, 1, LAT_SHORT);
    tick;
    b.in_valid = 1;
    b.in_data = '1;
    for (int i = 0; i < 13; i++) begin
      if (b.in_ready) acc_at.push_back(i);
      if (b.out_valid) chk("w17_count", b.out_count, 17);
      tick;
    end
    b.in_valid = 0;
    chk("w17_accepts", acc_at.size(), 4);
    if (acc_at.size() >= 3) begin
      chk("w17_interval1", acc_at[1] - acc_at[0], 4);
      chk("w17_interval2", acc_at[2] - acc_at[1], 4);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
